pong_ball_engine: RTL
=====================

// Module: pong_ball_engine
// PURPOSE
//  Parametrised ball controller for the Pong datapath: ball position, direction, speed.
//  Ball moves once per frame_tick. It bounces off the top and bottom walls and off both paddles.
//  A miss scores a point for the opponent; the ball then re-serves from centre after a delay.
//  Feeds the pixel renderer (ball_x/ball_y) and the score/sound logic (hit/point pulses).
// PARAMETERS
//  H_RES        800  playfield width, pixels
//  V_RES        600  playfield height, pixels
//  COORD_W      11   coordinate width; must satisfy 2**COORD_W > H_RES, V_RES
//  BALL_HALF    4    ball half-size; ball spans centre +/- BALL_HALF
//  PADDLE_LEN   80   paddle height, pixels
//  PADDLE1_X    16   inner face x of left paddle (player 1)
//  PADDLE2_X    784  inner face x of right paddle (player 2)
//  V_INIT       1    initial speed, pixels/tick per axis
//  V_MAX        4    speed ceiling
//  SPEEDUP_HITS 4    number of paddle hits per speed increment
//  SERVE_TICKS  60   number of frame ticks spent in SERVE
// PORTS
//  clk            in   1        master 50 MHz clock
//  reset          in   1        asynchronous, active-high reset
//  game_on        in   1        1 = run; 0 = pause (all state frozen)
//  frame_tick     in   1        one-cycle pulse, once per frame
//  paddle_pos1    in   COORD_W  left paddle top y
//  paddle_pos2    in   COORD_W  right paddle top y
//  ball_x         out  COORD_W  ball centre x
//  ball_y         out  COORD_W  ball centre y
//  ball_speed     out  3        current speed
//  serving        out  1        1 while in SERVE
//  wall_hit       out  1        one-cycle pulse on top/bottom bounce
//  paddle_hit     out  1        one-cycle pulse on paddle bounce
//  player1_point  out  1        one-cycle pulse: player 1 scored (ball passed right edge)
//  player2_point  out  1        one-cycle pulse: player 2 scored (ball passed left edge)
// BEHAVIOUR
//  Reset (async, active-high): state=SERVE, ball=(H_RES/2, V_RES/2), dir_x=+1, dir_y=+1.
//   Also: speed=V_INIT, hit_cnt=0, serve_cnt=0, all pulses 0.
//  Frame update condition: all updates occur on cycles with frame_tick && game_on.
//   Registered outputs change the following cycle; pulses are high for exactly that cycle.
//  game_on=0: position, state, counters held; pulses stay 0; a frame_tick during pause is dropped.
//  State SERVE: ball held at centre. serve_cnt counts ticks.
//   Leaves SERVE after SERVE_TICKS ticks -> PLAY.
//  State PLAY: nxt = pos +/- speed per axis. Compute in COORD_W+1 signed so underflow is impossible.
//   Y wall: if nxt_y-BALL_HALF <= 0, clamp y=BALL_HALF, dir_y=+1, wall_hit.
//    If nxt_y+BALL_HALF >= V_RES-1, clamp y=V_RES-1-BALL_HALF, dir_y=-1, wall_hit.
//   Left paddle (dir_x=-1): if nxt_x-BALL_HALF <= PADDLE1_X and paddle_pos1 <= ball_y < paddle_pos1+PADDLE_LEN,
//    clamp x=PADDLE1_X+BALL_HALF, dir_x=+1, paddle_hit.
//    Paddle inclusion compares the pre-move ball_y.
//   Right paddle: mirror of left (nxt_x+BALL_HALF >= PADDLE2_X), clamp x=PADDLE2_X-BALL_HALF.
//   Miss: nxt_x-BALL_HALF <= 0 -> player2_point. nxt_x+BALL_HALF >= H_RES-1 -> player1_point.
//    Either miss -> state SCORED.
//   Simultaneous wall and paddle hit on the same tick: both reflect, both pulses assert.
//   Paddle hit takes priority over miss on the same tick.
//  Speed: each paddle_hit increments hit_cnt.
//   On reaching SPEEDUP_HITS: hit_cnt=0, speed=min(speed+1, V_MAX), saturating.
//  State SCORED: lasts one clk cycle (not tick-gated).
//   Actions: ball->centre, speed=V_INIT, hit_cnt=0, serve_cnt=0, then -> SERVE.
//   New dir_x points toward the player who conceded; dir_y is kept.
//  Reset asserted mid-PLAY or mid-SCORED: immediate return to reset values, no pending pulse.
// STRUCTURE
//  Package pong_pkg: coord_t typedef, ball_state_e {SERVE, PLAY, SCORED}, H_RES/V_RES defaults.
//  Sub-module pong_axis_step, instantiated twice (x, y): step, clamp, reflect for one axis.
//   Inputs: pos, dir, speed, lo/hi bounds. Outputs: nxt_pos, nxt_dir, hit_lo, hit_hi.
//  Top level holds the FSM, speed/hit counters, serve timer, paddle-range compare.
// TESTING
//  1. Reset, game_on=1, 60 ticks -> serving drops; tick 61 gives ball=(401,301), speed=1.
//  2. Ball at y=5 moving up at speed 1 -> y=4, then wall_hit with y held at 4, dir_y=+1; one-cycle pulse.
//  3. Ball at x=21 moving left, paddle_pos1=ball_y-10 -> paddle_hit, x=20, dir_x=+1.
//     Same approach with paddle_pos1=ball_y+1 -> player2_point, then centre, SERVE.
//  4. 8 consecutive paddle hits -> speed 1->2->3. 16 further hits -> speed saturates at 4. Point -> speed 1.
//  5. Corner case: y and x boundaries reached on the same tick -> wall_hit and paddle_hit pulse together.
//  6. game_on=0 for 10 ticks mid-PLAY -> position frozen. Reset asserted between ticks -> centre, SERVE, pulses 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and playfield defaults for the Pong ball datapath.
package pong_pkg;

  localparam int unsigned H_RES_DEF   = 800;
  localparam int unsigned V_RES_DEF   = 600;
  localparam int unsigned COORD_W_DEF = 11;
  localparam int unsigned SPD_W       = 3;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } ball_state_e;

endpackage

// File: rtl/pong_axis_step.sv
// One-axis ball step: advance by speed, clamp to the lo/hi centre bounds and reflect.
module pong_axis_step
  import pong_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned SP_W    = SPD_W
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_i,
  input  logic [SP_W-1:0]    speed_i,
  input  logic [COORD_W-1:0] lo_i,
  input  logic [COORD_W-1:0] hi_i,
  output logic [COORD_W-1:0] nxt_pos_c_o,
  output logic               nxt_dir_c_o,
  output logic               hit_lo_c_o,
  output logic               hit_hi_c_o
);

  localparam int unsigned SW = COORD_W + 1;

  logic signed [SW-1:0] pos_s;
  logic signed [SW-1:0] step_s;
  logic signed [SW-1:0] lo_s;
  logic signed [SW-1:0] hi_s;
  logic signed [SW-1:0] nxt_s;

  // dir_i = 1 means moving toward lower coordinates; one extra bit keeps underflow visible
  always_comb begin
    pos_s       = $signed({1'b0, pos_i});
    step_s      = $signed(SW'(speed_i));
    lo_s        = $signed({1'b0, lo_i});
    hi_s        = $signed({1'b0, hi_i});
    nxt_s       = dir_i ? (pos_s - step_s) : (pos_s + step_s);
    hit_lo_c_o  = dir_i && (nxt_s <= lo_s);
    hit_hi_c_o  = !dir_i && (nxt_s >= hi_s);
    nxt_pos_c_o = COORD_W'(nxt_s);
    nxt_dir_c_o = dir_i;
    if (hit_lo_c_o) begin
      nxt_pos_c_o = lo_i;
      nxt_dir_c_o = 1'b0;
    end else if (hit_hi_c_o) begin
      nxt_pos_c_o = hi_i;
      nxt_dir_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball controller: serve/play/score FSM, position update per frame tick,
// wall and paddle bounces, speed-up after repeated paddle hits.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = H_RES_DEF,
  parameter int unsigned V_RES        = V_RES_DEF,
  parameter int unsigned COORD_W      = COORD_W_DEF,
  parameter int unsigned BALL_HALF    = 4,
  parameter int unsigned PADDLE_LEN   = 80,
  parameter int unsigned PADDLE1_X    = 16,
  parameter int unsigned PADDLE2_X    = 784,
  parameter int unsigned V_INIT       = 1,
  parameter int unsigned V_MAX        = 4,
  parameter int unsigned SPEEDUP_HITS = 4,
  parameter int unsigned SERVE_TICKS  = 60
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               game_on_i,
  input  logic               frame_tick_i,
  input  logic [COORD_W-1:0] paddle_pos1_i,
  input  logic [COORD_W-1:0] paddle_pos2_i,
  output logic [COORD_W-1:0] ball_x_o,
  output logic [COORD_W-1:0] ball_y_o,
  output logic [SPD_W-1:0]   ball_speed_o,
  output logic               serving_o,
  output logic               wall_hit_o,
  output logic               paddle_hit_o,
  output logic               player1_point_o,
  output logic               player2_point_o
);

  localparam int unsigned HC_W = $clog2(SPEEDUP_HITS + 1);
  localparam int unsigned SC_W = $clog2(SERVE_TICKS + 1);
  localparam int unsigned CW1  = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_CTR     = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] Y_CTR     = COORD_W'(V_RES / 2);
  localparam logic [COORD_W-1:0] Y_LO      = COORD_W'(BALL_HALF);
  localparam logic [COORD_W-1:0] Y_HI      = COORD_W'(V_RES - 1 - BALL_HALF);
  localparam logic [COORD_W-1:0] X_WALL_LO = COORD_W'(BALL_HALF);
  localparam logic [COORD_W-1:0] X_WALL_HI = COORD_W'(H_RES - 1 - BALL_HALF);
  localparam logic [COORD_W-1:0] X_PAD_LO  = COORD_W'(PADDLE1_X + BALL_HALF);
  localparam logic [COORD_W-1:0] X_PAD_HI  = COORD_W'(PADDLE2_X - BALL_HALF);

  ball_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dxn_q, dxn_d, dyn_q, dyn_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [SC_W-1:0]    serve_cnt_q, serve_cnt_d;
  logic               serving_q, serving_d;
  logic               wall_q, wall_d, paddle_q, paddle_d;
  logic               p1_q, p1_d, p2_q, p2_d;

  logic               upd;
  logic               cover1, cover2;
  logic [COORD_W-1:0] x_lo, x_hi;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               x_dir_nxt, y_dir_nxt;
  logic               x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
  logic               bounce, miss_l, miss_r;

  assign upd = game_on_i && frame_tick_i;

  // Paddle coverage uses the pre-move ball centre
  assign cover1 = (paddle_pos1_i <= y_q) &&
                  ({1'b0, y_q} < ({1'b0, paddle_pos1_i} + CW1'(PADDLE_LEN)));
  assign cover2 = (paddle_pos2_i <= y_q) &&
                  ({1'b0, y_q} < ({1'b0, paddle_pos2_i} + CW1'(PADDLE_LEN)));

  // An uncovered side lets the ball run on to the scoring edge
  assign x_lo = cover1 ? X_PAD_LO : X_WALL_LO;
  assign x_hi = cover2 ? X_PAD_HI : X_WALL_HI;

  pong_axis_step #(.COORD_W(COORD_W), .SP_W(SPD_W)) u_step_x (
    .pos_i       (x_q),
    .dir_i       (dxn_q),
    .speed_i     (speed_q),
    .lo_i        (x_lo),
    .hi_i        (x_hi),
    .nxt_pos_c_o (x_nxt),
    .nxt_dir_c_o (x_dir_nxt),
    .hit_lo_c_o  (x_hit_lo),
    .hit_hi_c_o  (x_hit_hi)
  );

  pong_axis_step #(.COORD_W(COORD_W), .SP_W(SPD_W)) u_step_y (
    .pos_i       (y_q),
    .dir_i       (dyn_q),
    .speed_i     (speed_q),
    .lo_i        (Y_LO),
    .hi_i        (Y_HI),
    .nxt_pos_c_o (y_nxt),
    .nxt_dir_c_o (y_dir_nxt),
    .hit_lo_c_o  (y_hit_lo),
    .hit_hi_c_o  (y_hit_hi)
  );

  assign bounce = (x_hit_lo && cover1) || (x_hit_hi && cover2);
  assign miss_l = x_hit_lo && !cover1;
  assign miss_r = x_hit_hi && !cover2;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dxn_d       = dxn_q;
    dyn_d       = dyn_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    serve_cnt_d = serve_cnt_q;
    wall_d      = 1'b0;
    paddle_d    = 1'b0;
    p1_d        = 1'b0;
    p2_d        = 1'b0;
    unique case (state_q)
      SERVE: begin
        if (upd) begin
          if (serve_cnt_q == SC_W'(SERVE_TICKS - 1)) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SC_W'(1);
          end
        end
      end
      PLAY: begin
        if (upd) begin
          y_d    = y_nxt;
          dyn_d  = y_dir_nxt;
          wall_d = y_hit_lo || y_hit_hi;
          x_d    = x_nxt;
          // A miss keeps dir_x, so the re-serve heads toward the conceding player
          if (bounce) begin
            dxn_d    = x_dir_nxt;
            paddle_d = 1'b1;
            if (hit_cnt_q == HC_W'(SPEEDUP_HITS - 1)) begin
              hit_cnt_d = '0;
              if (speed_q < SPD_W'(V_MAX)) speed_d = speed_q + SPD_W'(1);
            end else begin
              hit_cnt_d = hit_cnt_q + HC_W'(1);
            end
          end
          p2_d = miss_l;
          p1_d = miss_r;
          if (miss_l || miss_r) state_d = SCORED;
        end
      end
      SCORED: begin
        if (game_on_i) begin
          x_d         = X_CTR;
          y_d         = Y_CTR;
          speed_d     = SPD_W'(V_INIT);
          hit_cnt_d   = '0;
          serve_cnt_d = '0;
          state_d     = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
    serving_d = (state_d == SERVE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= SERVE;
      x_q         <= X_CTR;
      y_q         <= Y_CTR;
      dxn_q       <= 1'b0;
      dyn_q       <= 1'b0;
      speed_q     <= SPD_W'(V_INIT);
      hit_cnt_q   <= '0;
      serve_cnt_q <= '0;
      serving_q   <= 1'b1;
      wall_q      <= 1'b0;
      paddle_q    <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dxn_q       <= dxn_d;
      dyn_q       <= dyn_d;
      speed_q     <= speed_d;
      hit_cnt_q   <= hit_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      serving_q   <= serving_d;
      wall_q      <= wall_d;
      paddle_q    <= paddle_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  assign ball_x_o        = x_q;
  assign ball_y_o        = y_q;
  assign ball_speed_o    = speed_q;
  assign serving_o       = serving_q;
  assign wall_hit_o      = wall_q;
  assign paddle_hit_o    = paddle_q;
  assign player1_point_o = p1_q;
  assign player2_point_o = p2_q;

endmodule
